uart_rgb_ctrl: RTL and testbench

Parametrised UART command receiver that drives NUM_CH common-anode RGB LEDs, the successor of the single-byte r/g/b LED decoder on the board top level. It receives 8N1 serial bytes from the internal-oscillator clock domain, validates framing, and interprets a small ASCII command set. The command set supports per-channel addressing, eight colours and optional PWM brightness. It sits between the `uart_rx` pad and the RGB driver pins, with `int_clk` supplied by `SB_HFOSC`.

---
 rtl/uart_rgb_pkg.sv | 66 ++++++
 rtl/uart_rgb_ctrl_if.sv | 37 +++
 rtl/uart_rx_core.sv | 157 +++++++++++++++
 rtl/uart_rgb_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rgb_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rgb_pkg.sv
//==============================================================================
// Module      : uart_rgb_pkg
// Description : Shared definitions for the UART RGB controller. Holds the
//               ASCII command constants, the 3-bit colour encoding with the
//               letter-to-colour decode, the receiver state enum and the
//               ALL channel-selector encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_rgb_pkg;

    // ASCII command bytes
    localparam logic [7:0] c_ascii_zero  = 8'h30;  // '0'
    localparam logic [7:0] c_ascii_nine  = 8'h39;  // '9'
    localparam logic [7:0] c_ascii_star  = 8'h2A;  // '*'
    localparam logic [7:0] c_ascii_plus  = 8'h2B;  // '+'
    localparam logic [7:0] c_ascii_minus = 8'h2D;  // '-'

    // Colour encoding: bit 2 = red, bit 1 = green, bit 0 = blue (1 = lit)
    typedef logic [2:0] colour_t;

    localparam colour_t c_col_off   = 3'b000;
    localparam colour_t c_col_red   = 3'b100;
    localparam colour_t c_col_green = 3'b010;
    localparam colour_t c_col_blue  = 3'b001;

    typedef struct packed {
        logic    hit;     // byte is a colour letter
        colour_t colour;  // lit set for that letter
    } colour_cmd_t;

    // Receiver states
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Channel selector value meaning "every channel"
    localparam logic [3:0] c_sel_all = 4'hF;

    // Lowercase colour letter to lit set; anything else reports no hit.
    function automatic colour_cmd_t letter_to_colour(input logic [7:0] b);
        colour_cmd_t cmd;
        cmd.hit    = 1'b1;
        cmd.colour = c_col_off;
        case (b)
            8'h72:   cmd.colour = c_col_red;                          // 'r'
            8'h67:   cmd.colour = c_col_green;                        // 'g'
            8'h62:   cmd.colour = c_col_blue;                         // 'b'
            8'h63:   cmd.colour = c_col_green | c_col_blue;           // 'c'
            8'h6D:   cmd.colour = c_col_red | c_col_blue;             // 'm'
            8'h79:   cmd.colour = c_col_red | c_col_green;            // 'y'
            8'h77:   cmd.colour = c_col_red | c_col_green | c_col_blue; // 'w'
            8'h6B:   cmd.colour = c_col_off;                          // 'k'
            default: cmd.hit    = 1'b0;
        endcase
        return cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rgb_ctrl_if.sv
//==============================================================================
// Module      : uart_rgb_ctrl_if
// Description : Pin bundle of the UART RGB controller.
//               uart_rx   - serial input, idle high
//               rgb_*     - active-low LED enables, one bit per channel
//               rx_valid  - one-cycle pulse per well-framed byte
//               rx_byte   - last well-framed byte
//               frame_err - one-cycle pulse on a low stop bit
//               slave  modport: the controller side
//               master modport: the board / stimulus side
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_rgb_ctrl_if #(
    parameter int NUM_CH = 2
);
    logic              uart_rx;
    logic [NUM_CH-1:0] rgb_red;
    logic [NUM_CH-1:0] rgb_green;
    logic [NUM_CH-1:0] rgb_blue;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              frame_err;

    modport slave (
        input  uart_rx,
        output rgb_red, rgb_green, rgb_blue, rx_valid, rx_byte, frame_err
    );

    modport master (
        output uart_rx,
        input  rgb_red, rgb_green, rgb_blue, rx_valid, rx_byte, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_core.sv
//==============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver. Two-flop synchroniser, start-bit
//               qualification at mid-bit, LSB-first data sampling every DIV
//               cycles and stop-bit check. A low stop bit produces a single
//               frame_err and the receiver then waits for the line to return
//               high before looking for a new start bit.
//               Ports: int_clk, rst (async, active high), uart_rx in;
//                      rx_valid, rx_byte, frame_err out.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_core
    import uart_rgb_pkg::*;
#(
    parameter int DIV = 104
) (
    input  wire logic       int_clk,
    input  wire logic       rst,
    input  wire logic       uart_rx,
    output logic            rx_valid,
    output logic [7:0]      rx_byte,
    output logic            frame_err
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] c_half_load = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] c_full_load = CW'(DIV - 1);

    logic            r_meta;
    logic            r_synced;
    logic            r_synced_prev;
    logic            w_fall;

    rx_state_t       r_state,  w_state_n;
    logic [CW-1:0]   r_cnt,    w_cnt_n;
    logic [2:0]      r_bit,    w_bit_n;
    logic [7:0]      r_shift,  w_shift_n;
    logic [7:0]      r_byte,   w_byte_n;
    logic            r_valid,  w_valid_n;
    logic            r_ferr,   w_ferr_n;

    // Synchroniser plus one history flop for edge detection; all idle high.
    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            r_meta        <= 1'b1;
            r_synced      <= 1'b1;
            r_synced_prev <= 1'b1;
        end else begin
            r_meta        <= uart_rx;
            r_synced      <= r_meta;
            r_synced_prev <= r_synced;
        end
    end

    assign w_fall = r_synced_prev & ~r_synced;

    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_byte  <= w_byte_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_byte_n  = r_byte;
        w_valid_n = 1'b0;
        w_ferr_n  = 1'b0;

        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_cnt_n   = c_half_load;
                    w_state_n = RX_START;
                end
            end

            // Counter reaches 0 in the middle of the start bit.
            RX_START: begin
                if (r_cnt == '0) begin
                    if (r_synced) begin
                        w_state_n = RX_IDLE;
                    end else begin
                        w_cnt_n   = c_full_load;
                        w_bit_n   = 3'd0;
                        w_state_n = RX_DATA;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end

            RX_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_n = {r_synced, r_shift[7:1]};
                    w_cnt_n   = c_full_load;
                    if (r_bit == 3'd7) begin
                        w_state_n = RX_STOP;
                    end else begin
                        w_bit_n = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end

            RX_STOP: begin
                if (r_cnt == '0) begin
                    if (r_synced) begin
                        w_byte_n  = r_shift;
                        w_valid_n = 1'b1;
                        w_state_n = RX_IDLE;
                    end else begin
                        w_ferr_n  = 1'b1;
                        w_state_n = RX_BREAK;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end

            // Held-low line: stay here so only one frame_err is reported.
            RX_BREAK: begin
                if (r_synced) begin
                    w_state_n = RX_IDLE;
                end
            end

            default: w_state_n = RX_IDLE;
        endcase
    end

    assign rx_valid  = r_valid;
    assign rx_byte   = r_byte;
    assign frame_err = r_ferr;

endmodule

`default_nettype wire

// File: rtl/uart_rgb_ctrl.sv
//==============================================================================
// Module      : uart_rgb_ctrl
// Description : UART command receiver driving NUM_CH common-anode RGB LEDs.
//               Digits select a channel, '*' selects all, colour letters
//               (r g b c m y w k) set the lit set of the selected channel(s).
//               Optional global brightness via PWM when RGB_PWM_EN is defined
//               ('+' / '-' step the level); otherwise lit colours are driven
//               steadily low.
//               Ports: int_clk, rst (async, active high),
//                      bus (uart_rgb_ctrl_if.slave): uart_rx in; rgb_red,
//                      rgb_green, rgb_blue, rx_valid, rx_byte, frame_err out.
//               Macro: RGB_PWM_EN
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rgb_ctrl
    import uart_rgb_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200,
    parameter int NUM_CH   = 2,
    parameter int PWM_BITS = 4
) (
    input  wire logic       int_clk,
    input  wire logic       rst,
    uart_rgb_ctrl_if.slave  bus
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam logic [3:0] c_num_ch = 4'(NUM_CH);

    logic                   w_rx_valid;
    logic [7:0]             w_rx_byte;
    logic                   w_frame_err;

    colour_cmd_t            w_cmd;
    logic                   w_is_digit;
    logic [7:0]             w_digit_full;
    logic [3:0]             w_digit;

    logic [3:0]             r_sel;
    colour_t [NUM_CH-1:0]   r_colour;
    logic                   w_pwm_on;

    logic [NUM_CH-1:0]      w_red;
    logic [NUM_CH-1:0]      w_green;
    logic [NUM_CH-1:0]      w_blue;

    uart_rx_core #(
        .DIV (DIV)
    ) u_rx (
        .int_clk   (int_clk),
        .rst       (rst),
        .uart_rx   (bus.uart_rx),
        .rx_valid  (w_rx_valid),
        .rx_byte   (w_rx_byte),
        .frame_err (w_frame_err)
    );

    assign w_cmd        = letter_to_colour(w_rx_byte);
    assign w_is_digit   = (w_rx_byte >= c_ascii_zero) && (w_rx_byte <= c_ascii_nine);
    assign w_digit_full = w_rx_byte - c_ascii_zero;
    assign w_digit      = w_digit_full[3:0];

    // Channel selector; digits beyond the channel count leave it unchanged.
    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            r_sel <= c_sel_all;
        end else if (w_rx_valid) begin
            if (w_is_digit && (w_digit < c_num_ch)) begin
                r_sel <= w_digit;
            end else if (w_rx_byte == c_ascii_star) begin
                r_sel <= c_sel_all;
            end
        end
    end

    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            r_colour <= '0;
        end else if (w_rx_valid && w_cmd.hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((r_sel == c_sel_all) || (r_sel == 4'(i))) begin
                    r_colour[i] <= w_cmd.colour;
                end
            end
        end
    end

`ifdef RGB_PWM_EN
    localparam logic [PWM_BITS-1:0] c_level_max = '1;

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] r_pwm_cnt;

    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            r_level <= c_level_max;
        end else if (w_rx_valid) begin
            if ((w_rx_byte == c_ascii_plus) && (r_level != c_level_max)) begin
                r_level <= r_level + 1'b1;
            end else if ((w_rx_byte == c_ascii_minus) && (r_level != '0)) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge int_clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Full level bypasses the compare so maximum brightness is truly steady.
    assign w_pwm_on = (r_level == c_level_max) || (r_pwm_cnt < r_level);
`else
    // Without brightness control every lit colour is enabled continuously;
    // any legal PWM_BITS value yields a constant enable here.
    assign w_pwm_on = (PWM_BITS != 0);
`endif

    always_comb begin
        w_red   = '1;
        w_green = '1;
        w_blue  = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            w_red[i]   = ~(r_colour[i][2] & w_pwm_on);
            w_green[i] = ~(r_colour[i][1] & w_pwm_on);
            w_blue[i]  = ~(r_colour[i][0] & w_pwm_on);
        end
    end

    assign bus.rgb_red   = w_red;
    assign bus.rgb_green = w_green;
    assign bus.rgb_blue  = w_blue;
    assign bus.rx_valid  = w_rx_valid;
    assign bus.rx_byte   = w_rx_byte;
    assign bus.frame_err = w_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rgb_ctrl.sv
//==============================================================================
// Module      : tb_uart_rgb_ctrl
// Description : Self-checking bench for uart_rgb_ctrl. Serial frames are
//               driven on uart_rx; a reference model of the command set
//               predicts each received byte and the LED pins that follow it.
//               Macro: RGB_PWM_EN (enables the brightness section)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rgb_ctrl;

    localparam int NUM_CH = 2;
    localparam int DIV    = 12000000 / 115200;
    localparam int LW     = 3 * NUM_CH;

    typedef struct {
        logic [7:0]    b;
        logic [LW-1:0] leds;      // {red, green, blue} pin vectors
        bit            chk_led;   // pins are steady only at full brightness
    } exp_t;

    logic int_clk = 1'b0;
    logic rst;

    always #5 int_clk = ~int_clk;

    uart_rgb_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    uart_rgb_ctrl #(
        .CLK_FREQ (12000000),
        .BAUD     (115200),
        .NUM_CH   (NUM_CH),
        .PWM_BITS (4)
    ) dut (
        .int_clk (int_clk),
        .rst     (rst),
        .bus     (bus)
    );

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   got_ferr = 0;
    int   exp_ferr = 0;

    // Reference model: selected channel (-1 = all), lit set {R,G,B} per channel
    int         m_sel;
    logic [2:0] m_col [NUM_CH];
    int         m_level;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_sel   = -1;
        m_level = 15;
        for (int c = 0; c < NUM_CH; c++) m_col[c] = 3'b000;
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        logic [2:0] lit;
        bit         is_col;
        is_col = 1'b1;
        case (b)
            "r": lit = 3'b100;
            "g": lit = 3'b010;
            "b": lit = 3'b001;
            "c": lit = 3'b011;
            "m": lit = 3'b101;
            "y": lit = 3'b110;
            "w": lit = 3'b111;
            "k": lit = 3'b000;
            default: begin lit = 3'b000; is_col = 1'b0; end
        endcase
        if (b >= "0" && b <= "9") begin
            if (int'(b) - int'("0") < NUM_CH) m_sel = int'(b) - int'("0");
        end else if (b == "*") begin
            m_sel = -1;
        end else if (is_col) begin
            for (int c = 0; c < NUM_CH; c++)
                if (m_sel < 0 || m_sel == c) m_col[c] = lit;
        end
`ifdef RGB_PWM_EN
        if (b == "+" && m_level < 15) m_level++;
        if (b == "-" && m_level > 0)  m_level--;
`endif
    endfunction

    function automatic logic [LW-1:0] model_leds();
        logic [NUM_CH-1:0] r, g, bl;
        for (int c = 0; c < NUM_CH; c++) begin
            r[c]  = ~m_col[c][2];
            g[c]  = ~m_col[c][1];
            bl[c] = ~m_col[c][0];
        end
        return {r, g, bl};
    endfunction

    function automatic logic [LW-1:0] dut_leds();
        return {bus.rgb_red, bus.rgb_green, bus.rgb_blue};
    endfunction

    // Drives start, 8 data bits LSB first and the given stop level; the line
    // is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge int_clk) bus.uart_rx = 1'b0;
        repeat (DIV - 1) @(negedge int_clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge int_clk) bus.uart_rx = b[i];
            repeat (DIV - 1) @(negedge int_clk);
        end
        @(negedge int_clk) bus.uart_rx = stop;
        repeat (DIV - 1) @(negedge int_clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        exp_t e;
        model_apply(b);
        e.b       = b;
        e.leds    = model_leds();
        e.chk_led = (m_level == 15);
        q.push_back(e);
        send_frame(b, 1'b1);
        repeat ($urandom_range(0, DIV / 2)) @(negedge int_clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_cmd(s[i]);
    endtask

    task automatic monitor();
        exp_t e;
        bit   pending = 1'b0;
        forever begin
            @(negedge int_clk);
            if (pending) begin
                check("led_pins", 32'(dut_leds()), 32'(e.leds));
                pending = 1'b0;
            end
            if (bus.rx_valid && bus.frame_err) begin
                n_checks++;
                n_errors++;
                $display("FAIL pulse_overlap: rx_valid and frame_err both 1 at %0t", $time);
            end
            if (bus.frame_err) got_ferr++;
            if (bus.rx_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_rx_valid: got byte %0h expected none at %0t",
                             bus.rx_byte, $time);
                end else begin
                    e = q.pop_front();
                    check("rx_byte", 32'(bus.rx_byte), 32'(e.b));
                    pending = e.chk_led;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge int_clk) rst = 1'b1;
        model_reset();
        repeat (3) @(negedge int_clk);
        rst = 1'b0;
    endtask

`ifdef RGB_PWM_EN
    // Cycles within a window of 32 where channel 0 red is driven low.
    task automatic count_lit(output int lit);
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge int_clk);
            if (bus.rgb_red[0] == 1'b0) lit++;
        end
    endtask
`endif

    initial begin
        string pool;
        logic [7:0] b;
        pool = "0123456789*rgbcmywkRGBx+-";
        rst         = 1'b1;
        bus.uart_rx = 1'b1;
        model_reset();
        fork
            monitor();
        join_none

        // Reset state
        repeat (4) @(negedge int_clk);
        check("reset_leds", 32'(dut_leds()), {(32 - LW)'(0), {LW{1'b1}}});
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge int_clk);

        // All green; single channel addressing; out-of-range digit
        send_str("g1mk7b");

        // Bad stop bit followed by a line held low for three byte times
        send_frame(8'h55, 1'b0);
        exp_ferr++;
        repeat (30 * DIV) @(negedge int_clk);
        bus.uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge int_clk);
        check("frame_err_count", 32'(got_ferr), 32'(exp_ferr));
        check("leds_after_break", 32'(dut_leds()), 32'(model_leds()));
        send_cmd("r");

        // Glitch shorter than half a bit
        @(negedge int_clk) bus.uart_rx = 1'b0;
        repeat (DIV / 4) @(negedge int_clk);
        bus.uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge int_clk);
        check("false_start_ferr", 32'(got_ferr), 32'(exp_ferr));
        send_str("c1y");

        // Reset in the middle of a byte
        @(negedge int_clk) bus.uart_rx = 1'b0;
        repeat (5 * DIV) @(negedge int_clk);
        rst = 1'b1;
        #1;
        check("async_reset_leds", 32'(dut_leds()), {(32 - LW)'(0), {LW{1'b1}}});
        model_reset();
        repeat (3) @(negedge int_clk);
        bus.uart_rx = 1'b1;
        rst = 1'b0;
        repeat (2 * DIV) @(negedge int_clk);
        send_cmd("b");

        // Randomised command stream
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, pool.len() - 1)];
            send_cmd(b);
        end

`ifdef RGB_PWM_EN
        begin
            int lit;
            do_reset();
            repeat (2 * DIV) @(negedge int_clk);
            send_cmd("w");
            count_lit(lit);
            check("pwm_full_lit", 32'(lit), 32'd32);
            for (int n = 0; n < 8; n++) send_cmd("-");
            count_lit(lit);
            check("pwm_level7_lit", 32'(lit), 32'd14);
            for (int n = 0; n < 20; n++) send_cmd("+");
            count_lit(lit);
            check("pwm_saturate_lit", 32'(lit), 32'd32);
        end
`endif

        // Drain the scoreboard, bounded
        for (int i = 0; i < 4 * DIV && q.size() != 0; i++) @(negedge int_clk);
        repeat (3) @(negedge int_clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("final_frame_err_count", 32'(got_ferr), 32'(exp_ferr));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
